// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer for the shared 32-bit ALU: arbitrates opcode and PC-increment
// requests, holds one-hot ALU controls, then captures Chigh/Clow and pulses HI/LO enables.
module alu_op_sequencer #(
   parameter int MULDIV_CYCLES = 4
) (
   input  logic        i_clock,
   input  logic        i_clear,
   input  logic        i_start,
   input  logic [4:0]  i_opcode,
   input  logic        i_inc_req,
   input  logic [31:0] i_chigh_in,
   input  logic [31:0] i_clow_in,
   output logic [13:0] o_alu_ctl,
   output logic        o_ready,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_done_src,
   output logic        o_illegal,
   output logic        o_lo_we,
   output logic        o_hi_we,
   output logic [31:0] o_z_low,
   output logic [31:0] o_z_high
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [5:0]  MD_LOAD   = 6'(MULDIV_CYCLES - 1);
   localparam logic [13:0] CTL_INCPC = 14'h2000;

   // Opcode to one-hot ALU control; an all-zero result marks an illegal opcode.
   function automatic logic [13:0] decode_op(input logic [4:0] op);
      logic [13:0] ctl;
      ctl = 14'h0000;
      case (op)
         5'b00011: ctl = 14'h0001;  // ADD
         5'b00100: ctl = 14'h0002;  // SUB
         5'b01111: ctl = 14'h0004;  // MUL
         5'b10000: ctl = 14'h0008;  // DIV
         5'b01010: ctl = 14'h0010;  // AND
         5'b01011: ctl = 14'h0020;  // OR
         5'b00101: ctl = 14'h0040;  // SHR
         5'b00110: ctl = 14'h0080;  // SHRA
         5'b00111: ctl = 14'h0100;  // SHL
         5'b01000: ctl = 14'h0200;  // ROR
         5'b01001: ctl = 14'h0400;  // ROL
         5'b10001: ctl = 14'h0800;  // NEG
         5'b10010: ctl = 14'h1000;  // NOT
         default:  ctl = 14'h0000;
      endcase
      return ctl;
   endfunction

   state_t      r_state;
   state_t      w_next_state;
   logic [13:0] r_ctl;
   logic [5:0]  r_cnt;
   logic        r_muldiv;
   logic        r_done_src;
   logic        r_illegal;
   logic [31:0] r_z_low;
   logic [31:0] r_z_high;

   logic [13:0] w_dec;
   logic        w_legal;
   logic        w_dec_muldiv;
   logic        w_idle;
   logic        w_accept_op;
   logic        w_accept_inc;
   logic        w_last;

   assign w_dec        = decode_op(i_opcode);
   assign w_legal      = |w_dec;
   assign w_dec_muldiv = w_dec[2] | w_dec[3];
   assign w_idle       = (r_state == S_IDLE);
   assign w_accept_op  = w_idle && i_start && w_legal;
   assign w_accept_inc = w_idle && !i_start && i_inc_req;
   assign w_last       = (r_state == S_EXEC) && (r_cnt == 6'd0);

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values, independent of the order of statements or processes.
   always_ff @(posedge i_clock) begin
      if (i_clear) r_state <= S_IDLE;
      else         r_state <= w_next_state;
   end

   // NOTE: the default assignment first guarantees w_next_state is driven on every
   // path, so no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_accept_op || w_accept_inc) w_next_state = S_EXEC;
         S_EXEC:  if (w_last) w_next_state = S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_clear) begin
         r_ctl      <= 14'h0000;
         r_cnt      <= 6'd0;
         r_muldiv   <= 1'b0;
         r_done_src <= 1'b0;
         r_illegal  <= 1'b0;
         r_z_low    <= 32'h0;
         r_z_high   <= 32'h0;
      end else begin
         // An illegal opcode blocks inc_req for that cycle because start still wins.
         r_illegal <= w_idle && i_start && !w_legal;
         if (w_accept_op) begin
            r_ctl      <= w_dec;
            r_muldiv   <= w_dec_muldiv;
            r_cnt      <= w_dec_muldiv ? MD_LOAD : 6'd0;
            r_done_src <= 1'b0;
         end else if (w_accept_inc) begin
            r_ctl      <= CTL_INCPC;
            r_muldiv   <= 1'b0;
            r_cnt      <= 6'd0;
            r_done_src <= 1'b1;
         end else if (r_state == S_EXEC) begin
            if (r_cnt != 6'd0) begin
               r_cnt <= r_cnt - 6'd1;
            end else begin
               r_z_low <= i_clow_in;
               if (r_muldiv) r_z_high <= i_chigh_in;
            end
         end
      end
   end

   assign o_ready    = w_idle;
   assign o_busy     = (r_state == S_EXEC) || (r_state == S_DONE);
   assign o_done     = (r_state == S_DONE);
   assign o_done_src = o_done && r_done_src;
   assign o_lo_we    = o_done;
   assign o_hi_we    = o_done && r_muldiv;
   assign o_alu_ctl  = (r_state == S_EXEC) ? r_ctl : 14'h0000;
   assign o_illegal  = r_illegal;
   assign o_z_low    = r_z_low;
   assign o_z_high   = r_z_high;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed-vector bench for alu_op_sequencer; expected values are hand-computed per scenario.
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        clear, start, inc_req;
   logic [4:0]  opcode;
   logic [31:0] chigh_in, clow_in;
   logic [13:0] alu_ctl;
   logic        ready, busy, done, done_src, illegal, lo_we, hi_we;
   logic [31:0] z_low, z_high;

   int n_vec = 0;
   int n_err = 0;

   // Flag order: ready busy done lo_we hi_we done_src illegal
   logic [6:0] flags;
   assign flags = {ready, busy, done, lo_we, hi_we, done_src, illegal};

   alu_op_sequencer #(.MULDIV_CYCLES(4)) dut (
      .i_clock(clk), .i_clear(clear), .i_start(start), .i_opcode(opcode),
      .i_inc_req(inc_req), .i_chigh_in(chigh_in), .i_clow_in(clow_in),
      .o_alu_ctl(alu_ctl), .o_ready(ready), .o_busy(busy), .o_done(done),
      .o_done_src(done_src), .o_illegal(illegal), .o_lo_we(lo_we), .o_hi_we(hi_we),
      .o_z_low(z_low), .o_z_high(z_high)
   );

   always #5 clk = ~clk;

   // Advance one cycle; outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clear = 1'b1; start = 1'b0; inc_req = 1'b0; opcode = 5'd0;
      chigh_in = 32'h0; clow_in = 32'h0;
      step(); step();
      n_vec++;
      if (flags !== 7'b1000000) begin
         n_err++; $display("FAIL reset_flags got=%b want=%b", flags, 7'b1000000);
      end
      n_vec++;
      if ({alu_ctl, z_low, z_high} !== 78'h0) begin
         n_err++; $display("FAIL reset_data got ctl=%h zl=%h zh=%h want all 0", alu_ctl, z_low, z_high);
      end
      clear = 1'b0;
      step();
   endtask

   task automatic test_add();
      start = 1'b1; opcode = 5'b00011;
      step();  // cycle 1
      start = 1'b0; clow_in = 32'd8;
      n_vec++;
      if (alu_ctl !== 14'h0001 || flags !== 7'b0100000) begin
         n_err++; $display("FAIL add_exec got ctl=%h flags=%b want ctl=0001 flags=0100000", alu_ctl, flags);
      end
      step();  // cycle 2
      n_vec++;
      if (flags !== 7'b0111000 || alu_ctl !== 14'h0 || z_low !== 32'd8 || z_high !== 32'h0) begin
         n_err++; $display("FAIL add_done got flags=%b ctl=%h zl=%h zh=%h want flags=0111000 ctl=0 zl=8 zh=0",
                           flags, alu_ctl, z_low, z_high);
      end
      step();  // cycle 3
      n_vec++;
      if (flags !== 7'b1000000) begin
         n_err++; $display("FAIL add_ready got=%b want=1000000", flags);
      end
   endtask

   task automatic test_mul();
      start = 1'b1; opcode = 5'b01111;
      chigh_in = 32'h1; clow_in = 32'hFFFF_FFFE;
      for (int c = 1; c <= 4; c++) begin
         step();
         start = 1'b0;
         n_vec++;
         if (alu_ctl !== 14'h0004 || flags !== 7'b0100000) begin
            n_err++; $display("FAIL mul_exec_c%0d got ctl=%h flags=%b want ctl=0004 flags=0100000", c, alu_ctl, flags);
         end
      end
      step();  // cycle 5
      n_vec++;
      if (flags !== 7'b0111100 || z_high !== 32'h1 || z_low !== 32'hFFFF_FFFE) begin
         n_err++; $display("FAIL mul_done got flags=%b zh=%h zl=%h want flags=0111100 zh=1 zl=fffffffe",
                           flags, z_high, z_low);
      end
      step();  // cycle 6
      n_vec++;
      if (flags !== 7'b1000000) begin
         n_err++; $display("FAIL mul_ready got=%b want=1000000", flags);
      end
   endtask

   task automatic test_start_during_exec();
      int n_done;
      n_done = 0;
      start = 1'b1; opcode = 5'b00111; clow_in = 32'h40; chigh_in = 32'hDEAD;
      step();  // cycle 1: EXEC SHL, pulse start with ADD
      opcode = 5'b00011;
      n_vec++;
      if (alu_ctl !== 14'h0100) begin
         n_err++; $display("FAIL shl_exec got ctl=%h want 0100", alu_ctl);
      end
      step();  // cycle 2
      start = 1'b0;
      n_done += int'(done);
      n_vec++;
      if (z_low !== 32'h40 || z_high !== 32'h1 || hi_we !== 1'b0) begin
         n_err++; $display("FAIL shl_done got zl=%h zh=%h hi_we=%b want zl=40 zh=1 hi_we=0", z_low, z_high, hi_we);
      end
      for (int c = 0; c < 4; c++) begin
         step();
         n_done += int'(done);
         n_vec++;
         if (alu_ctl !== 14'h0 || ready !== 1'b1) begin
            n_err++; $display("FAIL shl_after_c%0d got ctl=%h ready=%b want ctl=0 ready=1", c, alu_ctl, ready);
         end
      end
      n_vec++;
      if (n_done !== 1) begin
         n_err++; $display("FAIL shl_done_count got=%0d want=1", n_done);
      end
   endtask

   task automatic test_illegal();
      logic [4:0] bad [3];
      bad[0] = 5'b00000; bad[1] = 5'b01100; bad[2] = 5'b11111;
      for (int k = 0; k < 3; k++) begin
         start = 1'b1; opcode = bad[k];
         step();  // cycle 1
         start = 1'b0;
         n_vec++;
         if (flags !== 7'b1000001 || alu_ctl !== 14'h0) begin
            n_err++; $display("FAIL illegal_%b got flags=%b ctl=%h want flags=1000001 ctl=0", bad[k], flags, alu_ctl);
         end
         step();  // cycle 2
         n_vec++;
         if (flags !== 7'b1000000) begin
            n_err++; $display("FAIL illegal_clear_%b got=%b want=1000000", bad[k], flags);
         end
      end
      // Illegal start with inc_req high: increment waits one cycle.
      start = 1'b1; opcode = 5'b11110; inc_req = 1'b1; clow_in = 32'h99;
      step();  // cycle 1
      start = 1'b0;
      n_vec++;
      if (flags !== 7'b1000001 || alu_ctl !== 14'h0) begin
         n_err++; $display("FAIL illegal_inc_block got flags=%b ctl=%h want flags=1000001 ctl=0", flags, alu_ctl);
      end
      step();  // cycle 2
      n_vec++;
      if (alu_ctl !== 14'h2000) begin
         n_err++; $display("FAIL illegal_inc_late got ctl=%h want 2000", alu_ctl);
      end
      step();  // cycle 3
      inc_req = 1'b0;
      n_vec++;
      if (flags !== 7'b0111010 || z_low !== 32'h99) begin
         n_err++; $display("FAIL illegal_inc_done got flags=%b zl=%h want flags=0111010 zl=99", flags, z_low);
      end
      step();
   endtask

   task automatic test_arbitration();
      start = 1'b1; opcode = 5'b10010; inc_req = 1'b1; clow_in = 32'h5;
      step();  // cycle 1
      start = 1'b0;
      n_vec++;
      if (alu_ctl !== 14'h1000) begin
         n_err++; $display("FAIL arb_not_exec got ctl=%h want 1000", alu_ctl);
      end
      step();  // cycle 2
      n_vec++;
      if (flags !== 7'b0111000 || z_low !== 32'h5) begin
         n_err++; $display("FAIL arb_not_done got flags=%b zl=%h want flags=0111000 zl=5", flags, z_low);
      end
      step();  // cycle 3
      clow_in = 32'h7;
      n_vec++;
      if (flags !== 7'b1000000) begin
         n_err++; $display("FAIL arb_idle got=%b want=1000000", flags);
      end
      step();  // cycle 4
      n_vec++;
      if (alu_ctl !== 14'h2000 || busy !== 1'b1) begin
         n_err++; $display("FAIL arb_inc_exec got ctl=%h busy=%b want ctl=2000 busy=1", alu_ctl, busy);
      end
      step();  // cycle 5
      inc_req = 1'b0;
      n_vec++;
      if (flags !== 7'b0111010 || z_low !== 32'h7) begin
         n_err++; $display("FAIL arb_inc_done got flags=%b zl=%h want flags=0111010 zl=7", flags, z_low);
      end
      step();  // cycle 6
      n_vec++;
      if (flags !== 7'b1000000) begin
         n_err++; $display("FAIL arb_final got=%b want=1000000", flags);
      end
   endtask

   task automatic test_clear_mid_div();
      start = 1'b1; opcode = 5'b10000; chigh_in = 32'hAA; clow_in = 32'hBB;
      step();  // cycle 1
      start = 1'b0;
      n_vec++;
      if (alu_ctl !== 14'h0008) begin
         n_err++; $display("FAIL div_exec got ctl=%h want 0008", alu_ctl);
      end
      step();  // cycle 2
      clear = 1'b1;
      step();  // cycle 3
      clear = 1'b0;
      n_vec++;
      if (flags !== 7'b1000000 || {alu_ctl, z_low, z_high} !== 78'h0) begin
         n_err++; $display("FAIL div_clear got flags=%b ctl=%h zl=%h zh=%h want flags=1000000 ctl/zl/zh=0",
                           flags, alu_ctl, z_low, z_high);
      end
      for (int c = 0; c < 8; c++) begin
         step();
         n_vec++;
         if (done !== 1'b0 || hi_we !== 1'b0 || lo_we !== 1'b0 || alu_ctl !== 14'h0) begin
            n_err++; $display("FAIL div_after_clear_c%0d got done=%b hi_we=%b lo_we=%b ctl=%h want all 0",
                              c, done, hi_we, lo_we, alu_ctl);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_mul();
      test_start_during_exec();
      test_illegal();
      test_arbitration();
      test_clear_mid_div();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multi-cycle controller that sequences the shared 32-bit ALU. It accepts a 5-bit instruction opcode or a PC-increment request, arbitrates between the two, and drives the ALU's one-hot control lines for the required number of cycles. It then captures the ALU's Chigh/Clow outputs into result registers and pulses the HI/LO write enables. It sits between the control unit and the ALU/Z/HI/LO datapath.

## Interface
- MULDIV_CYCLES, 4: cycles MUL/DIV controls are held before capture; legal range 1..32
- clock  in  1  system clock, all state updates on rising edge
- clear  in  1  reset, synchronous, active-high
- start  in  1  instruction operation request, sampled only when ready=1
- opcode  in  5  operation code, sampled with start
- inc_req  in  1  PC-increment request, level; held by requester until done with done_src=1
- chigh_in  in  32  ALU Chigh output
- clow_in  in  32  ALU Clow output
- alu_ctl  out  14  one-hot ALU controls: [0]ADD [1]SUB [2]MUL [3]DIV [4]AND [5]OR [6]SHR [7]SHRA [8]SHL [9]ROR [10]ROL [11]NEG [12]NOT [13]IncPC
- ready  out  1  high only in IDLE
- busy  out  1  high in EXEC and DONE
- done  out  1  one-cycle pulse, result registers valid
- done_src  out  1  valid with done: 0 = opcode op, 1 = PC increment
- illegal  out  1  one-cycle pulse on rejected opcode
- lo_we  out  1  pulses with done, always
- hi_we  out  1  pulses with done for MUL/DIV only
- z_low  out  32  captured Clow
- z_high  out  32  captured Chigh

## Operation
- Opcode map: ADD 00011, SUB 00100, SHR 00101, SHRA 00110, SHL 00111, ROR 01000, ROL 01001, AND 01010, OR 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010. All other codes are illegal.
- States: IDLE, EXEC, DONE.
- IDLE → EXEC when start=1 with a legal opcode:
  - latch the opcode; done_src=0
  - load the counter with MULDIV_CYCLES-1 for MUL/DIV, otherwise 0
- IDLE, start=1 with an illegal opcode:
  - illegal=1 in the next cycle; remain in IDLE
  - inc_req is not served that cycle
- IDLE → EXEC when start=0 and inc_req=1:
  - latch IncPC; counter 0; done_src=1
- Arbitration: start has priority over inc_req when both are high in the same cycle.
- EXEC:
  - alu_ctl has exactly one bit set, for the latched op
  - the counter decrements each cycle
  - at the edge where the counter is 0: z_low ← clow_in
  - at the same edge, for MUL/DIV only: z_high ← chigh_in
  - same edge: go to DONE
  - non-MUL/DIV ops leave z_high unchanged
- DONE:
  - done=1, lo_we=1, hi_we=1 for MUL/DIV
  - alu_ctl=0
  - next state IDLE
- start and inc_req are ignored outside IDLE. They are not queued, except that inc_req is a held level.
- Counter width is 6 bits; it never wraps below 0.

## Timing
- Reset values (cycle after clear=1): state IDLE; ready=1; alu_ctl=0; busy/done/illegal/lo_we/hi_we/done_src=0; z_low=z_high=0; counter=0.
- clear in any state, including mid-EXEC:
  - forces all reset values on the next edge
  - the in-flight op is discarded; no done or write-enable pulse is issued
  - clear has priority over start and inc_req
- Let N = MULDIV_CYCLES for MUL/DIV, otherwise 1. For a request accepted at edge t:
  - EXEC occupies cycles t+1..t+N
  - DONE is cycle t+N+1
  - ready=1 again in cycle t+N+2
- Throughput: one op per N+2 cycles; simple ops take 3 cycles each.
- chigh_in/clow_in must be stable in the last EXEC cycle. They are sampled only at the final EXEC edge.
- illegal pulses in cycle t+1 only; ready remains 1 throughout.

## Test plan
- ADD (00011), start at cycle 0, bench drives clow_in=8:
  - alu_ctl=0x0001 in cycle 1
  - cycle 2: done=1, lo_we=1, hi_we=0, z_low=8, z_high unchanged
  - ready=1 in cycle 3
- MUL (01111) with MULDIV_CYCLES=4, chigh_in=0x1, clow_in=0xFFFFFFFE:
  - alu_ctl=0x0004 in cycles 1-4
  - cycle 5: done=1, hi_we=1, z_high=0x1, z_low=0xFFFFFFFE
- Illegal opcode 00000 with start=1:
  - illegal=1 in cycle 1
  - alu_ctl stays 0; ready stays 1; no done
- start (NOT, 10010) and inc_req both high at cycle 0, inc_req held:
  - NOT serviced first, done_src=0 in cycle 2
  - IncPC accepted at cycle 3, alu_ctl=0x2000 in cycle 4, done with done_src=1 in cycle 5
- clear=1 in cycle 2 of a DIV (MULDIV_CYCLES=4):
  - cycle 3: IDLE, all outputs at reset values
  - no done/hi_we pulses occur afterward
- start pulsed during EXEC of a SHL:
  - ignored; only one done pulse; alu_ctl unchanged
